// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the PC source each cycle, drives pipeline
// flushes, post-redirect fetch bubbles, halt/resume and redirect statistics.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR      = 32'h0000_0100,
  parameter bit          HAS_C            = 1'b1,
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        is_compressed,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] target,
  input  logic        trap,
  input  logic        mret,
  input  logic [31:0] epc,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        fetch_valid,
  output logic        misaligned,
  output logic        halted,
  output logic [15:0] redirect_count
);

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT, HALTED} state_t;

  localparam logic [2:0] LAST_BUBBLE =
    (REDIRECT_BUBBLES == 0) ? 3'd0 : 3'(REDIRECT_BUBBLES - 1);
  localparam state_t AFTER_REDIRECT = (REDIRECT_BUBBLES == 0) ? RUN : REDIRECT;

  state_t      state, state_n;
  logic [2:0]  bubble, bubble_n;
  logic        redirect;
  logic        mis_n;
  logic        mis_q;
  logic [31:0] tgt;

  always_comb begin
    pc_load     = 1'b0;
    pc_next     = pc_cur;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    fetch_valid = 1'b0;
    state_n     = state;
    bubble_n    = bubble;
    redirect    = 1'b0;
    mis_n       = 1'b0;
    tgt         = {target[31:1], 1'b0};

    case (state)
      BOOT: begin
        pc_load     = 1'b1;
        pc_next     = RESET_VECTOR;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        state_n     = RUN;
      end
      RUN: begin
        fetch_valid = 1'b1;
        if (trap) begin
          redirect = 1'b1;
          pc_next  = TRAP_VECTOR;
        end else if (mret) begin
          redirect = 1'b1;
          pc_next  = {epc[31:1], 1'b0};
        end else if (branch_taken || jump) begin
          redirect = 1'b1;
          // Without C support a halfword-aligned target is diverted to the trap vector.
          if (!HAS_C && tgt[1]) begin
            pc_next = TRAP_VECTOR;
            mis_n   = 1'b1;
          end else begin
            pc_next = tgt;
          end
        end else if (halt_req) begin
          flush_if_id = 1'b1;
          state_n     = HALTED;
        end else if (!stall) begin
          pc_load = 1'b1;
          pc_next = pc_cur + (is_compressed ? 32'd2 : 32'd4);
        end
      end
      REDIRECT: begin
        if (trap) begin
          redirect = 1'b1;
          pc_next  = TRAP_VECTOR;
        end else if (bubble == LAST_BUBBLE) begin
          state_n = RUN;
        end else begin
          bubble_n = bubble + 3'd1;
        end
      end
      HALTED: begin
        if (trap) begin
          redirect = 1'b1;
          pc_next  = TRAP_VECTOR;
        end else if (resume) begin
          state_n = RUN;
        end
      end
      default: state_n = BOOT;
    endcase

    if (redirect) begin
      pc_load     = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      state_n     = AFTER_REDIRECT;
      bubble_n    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= BOOT;
      bubble         <= '0;
      redirect_count <= '0;
      mis_q          <= 1'b0;
    end else begin
      state  <= state_n;
      bubble <= bubble_n;
      mis_q  <= mis_n;
      if (redirect && (redirect_count != '1))
        redirect_count <= redirect_count + 16'd1;
    end
  end

  assign misaligned = mis_q;
  assign halted     = (state == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: two configurations share stimulus, a
// behavioural model predicts each cycle's outputs into per-instance queues.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        is_compressed = 1'b0, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic        trap = 1'b0, mret = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] target = '0, epc = '0;
  logic [31:0] pc0, pc1;

  logic        a_load, a_fif, a_fex, a_fv, a_mis, a_hlt;
  logic [31:0] a_nxt;
  logic [15:0] a_cnt;
  logic        b_load, b_fif, b_fex, b_fv, b_mis, b_hlt;
  logic [31:0] b_nxt;
  logic [15:0] b_cnt;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100),
                 .HAS_C(1'b0), .REDIRECT_BUBBLES(1)) dut0 (
    .clk(clk), .rst(rst), .pc_cur(pc0), .is_compressed(is_compressed),
    .stall(stall), .branch_taken(branch_taken), .jump(jump), .target(target),
    .trap(trap), .mret(mret), .epc(epc), .halt_req(halt_req), .resume(resume),
    .pc_load(a_load), .pc_next(a_nxt), .flush_if_id(a_fif), .flush_id_ex(a_fex),
    .fetch_valid(a_fv), .misaligned(a_mis), .halted(a_hlt), .redirect_count(a_cnt));

  pc_sequencer #(.RESET_VECTOR(32'h0000_1000), .TRAP_VECTOR(32'h0000_0200),
                 .HAS_C(1'b1), .REDIRECT_BUBBLES(2)) dut1 (
    .clk(clk), .rst(rst), .pc_cur(pc1), .is_compressed(is_compressed),
    .stall(stall), .branch_taken(branch_taken), .jump(jump), .target(target),
    .trap(trap), .mret(mret), .epc(epc), .halt_req(halt_req), .resume(resume),
    .pc_load(b_load), .pc_next(b_nxt), .flush_if_id(b_fif), .flush_id_ex(b_fex),
    .fetch_valid(b_fv), .misaligned(b_mis), .halted(b_hlt), .redirect_count(b_cnt));

  typedef struct packed {
    logic        load;
    logic [31:0] nxt;
    logic        fif, fex, fv, mis, hlt;
    logic [15:0] cnt;
  } obs_t;

  obs_t q0[$], q1[$];
  int checks = 0, failures = 0;

  localparam int M_BOOT = 0, M_RUN = 1, M_BUB = 2, M_HALT = 3;
  int          m_mode[2], n_mode[2];
  int unsigned m_left[2], n_left[2];
  int unsigned m_cnt[2],  n_cnt[2];
  bit          m_mis[2],  n_mis[2];
  logic [31:0] m_pc[2],   n_pc[2];

  assign pc0 = m_pc[0];
  assign pc1 = m_pc[1];

  logic        s_rst, s_c, s_stall, s_br, s_jmp, s_trap, s_mret, s_halt, s_res;
  logic [31:0] s_tgt, s_epc;

  function automatic int unsigned cfg_bub(input int d);  return (d == 0) ? 1 : 2; endfunction
  function automatic bit cfg_hasc(input int d);          return d != 0; endfunction
  function automatic logic [31:0] cfg_rv(input int d);   return (d == 0) ? 32'h0 : 32'h1000; endfunction
  function automatic logic [31:0] cfg_tv(input int d);   return (d == 0) ? 32'h100 : 32'h200; endfunction

  task automatic model(input int d, output obs_t e);
    bit          redir = 1'b0;
    logic [31:0] dest = '0;
    logic [31:0] t;
    if (rst) begin
      m_mode[d] = M_BOOT; m_left[d] = 0; m_cnt[d] = 0; m_mis[d] = 1'b0;
    end
    e = '0;
    e.mis = m_mis[d];
    e.hlt = (m_mode[d] == M_HALT);
    e.cnt = 16'(m_cnt[d]);
    n_mode[d] = m_mode[d];
    n_left[d] = m_left[d];
    n_cnt[d]  = m_cnt[d];
    n_mis[d]  = 1'b0;
    if (m_mode[d] == M_BOOT) begin
      e.load = 1'b1; e.nxt = cfg_rv(d); e.fif = 1'b1; e.fex = 1'b1;
      n_mode[d] = M_RUN;
    end else if (m_mode[d] == M_RUN) begin
      e.fv = 1'b1;
      t = target & 32'hFFFF_FFFE;
      if (trap) begin redir = 1'b1; dest = cfg_tv(d); end
      else if (mret) begin redir = 1'b1; dest = epc & 32'hFFFF_FFFE; end
      else if (branch_taken || jump) begin
        redir = 1'b1;
        if (!cfg_hasc(d) && (t % 4 != 0)) begin dest = cfg_tv(d); n_mis[d] = 1'b1; end
        else dest = t;
      end
      else if (halt_req) begin e.fif = 1'b1; n_mode[d] = M_HALT; end
      else if (!stall) begin
        e.load = 1'b1;
        e.nxt  = m_pc[d] + (is_compressed ? 2 : 4);
      end
    end else if (m_mode[d] == M_BUB) begin
      if (trap) begin redir = 1'b1; dest = cfg_tv(d); end
      else begin
        n_left[d] = m_left[d] - 1;
        if (n_left[d] == 0) n_mode[d] = M_RUN;
      end
    end else begin
      if (trap) begin redir = 1'b1; dest = cfg_tv(d); end
      else if (resume) n_mode[d] = M_RUN;
    end
    if (redir) begin
      e.load = 1'b1; e.nxt = dest; e.fif = 1'b1; e.fex = 1'b1;
      n_cnt[d]  = (m_cnt[d] < 65535) ? m_cnt[d] + 1 : m_cnt[d];
      n_left[d] = cfg_bub(d);
      n_mode[d] = (cfg_bub(d) == 0) ? M_RUN : M_BUB;
    end
    n_pc[d] = e.load ? e.nxt : m_pc[d];
    if (rst) begin
      n_mode[d] = M_BOOT; n_left[d] = 0; n_cnt[d] = 0; n_mis[d] = 1'b0;
    end
  endtask

  task automatic clear_stim();
    s_rst = 0; s_stall = 0; s_br = 0; s_jmp = 0; s_trap = 0;
    s_mret = 0; s_halt = 0; s_res = 0;
  endtask

  task automatic step();
    obs_t e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = n_mode[d]; m_left[d] = n_left[d]; m_cnt[d] = n_cnt[d];
      m_mis[d] = n_mis[d];   m_pc[d] = n_pc[d];
    end
    rst = s_rst; is_compressed = s_c; stall = s_stall; branch_taken = s_br;
    jump = s_jmp; trap = s_trap; mret = s_mret; halt_req = s_halt;
    resume = s_res; target = s_tgt; epc = s_epc;
    #1;
    model(0, e); q0.push_back(e);
    model(1, e); q1.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic obs_t actual(input int d);
    if (d == 0) return {a_load, a_nxt, a_fif, a_fex, a_fv, a_mis, a_hlt, a_cnt};
    return {b_load, b_nxt, b_fif, b_fex, b_fv, b_mis, b_hlt, b_cnt};
  endfunction

  task automatic compare(input int d, input obs_t e);
    obs_t a = actual(d);
    chk($sformatf("dut%0d.pc_load", d), 32'(a.load), 32'(e.load));
    if (e.load) chk($sformatf("dut%0d.pc_next", d), a.nxt, e.nxt);
    chk($sformatf("dut%0d.flush_if_id", d), 32'(a.fif), 32'(e.fif));
    chk($sformatf("dut%0d.flush_id_ex", d), 32'(a.fex), 32'(e.fex));
    chk($sformatf("dut%0d.fetch_valid", d), 32'(a.fv), 32'(e.fv));
    chk($sformatf("dut%0d.misaligned", d), 32'(a.mis), 32'(e.mis));
    chk($sformatf("dut%0d.halted", d), 32'(a.hlt), 32'(e.hlt));
    chk($sformatf("dut%0d.redirect_count", d), 32'(a.cnt), 32'(e.cnt));
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q0.size() > 0) begin e = q0.pop_front(); compare(0, e); end
      while (q1.size() > 0) begin e = q1.pop_front(); compare(1, e); end
    end
  end

  initial begin : stimulus
    for (int d = 0; d < 2; d++) begin
      n_mode[d] = M_BOOT; n_left[d] = 0; n_cnt[d] = 0; n_mis[d] = 1'b0; n_pc[d] = '0;
    end
    clear_stim(); s_c = 0; s_tgt = '0; s_epc = '0;
    s_rst = 1; step(); step();
    s_rst = 0; repeat (5) step();
    s_c = 1; repeat (2) step(); s_c = 0;
    s_stall = 1; repeat (3) step(); s_stall = 0;
    s_br = 1; s_tgt = 32'h41; step(); s_br = 0; repeat (3) step();
    s_br = 1; s_tgt = 32'h42; step(); s_br = 0; repeat (3) step();
    s_trap = 1; s_br = 1; s_tgt = 32'h80; step();
    s_br = 0; step();
    s_trap = 0; repeat (4) step();
    s_halt = 1; step(); s_halt = 0; repeat (3) step();
    s_res = 1; step(); s_res = 0; repeat (2) step();
    s_halt = 1; step(); s_halt = 0; step();
    s_trap = 1; s_res = 1; step(); clear_stim(); repeat (3) step();
    s_mret = 1; s_epc = 32'h0000_0357; step(); s_mret = 0; repeat (3) step();
    s_jmp = 1; s_tgt = 32'hFFFF_FFF8; step(); s_jmp = 0; repeat (5) step();

    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom_range(0, 199) == 0);
      s_c     = 1'($urandom_range(0, 1));
      s_stall = ($urandom_range(0, 4) == 0);
      s_br    = ($urandom_range(0, 7) == 0);
      s_jmp   = ($urandom_range(0, 15) == 0);
      s_trap  = ($urandom_range(0, 19) == 0);
      s_mret  = ($urandom_range(0, 19) == 0);
      s_halt  = ($urandom_range(0, 15) == 0);
      s_res   = ($urandom_range(0, 3) == 0);
      s_tgt   = $urandom;
      s_epc   = $urandom;
      step();
    end

    clear_stim(); repeat (4) step();
    s_trap = 1; repeat (65540) step();
    s_trap = 0; repeat (4) step();
    s_br = 1; s_tgt = 32'h0000_0040; step();
    s_br = 0; s_rst = 1; step();
    s_rst = 0; repeat (4) step();

    repeat (2) @(negedge clk);
    #5;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
